// File: rtl/wr_ptr_full.sv
// Write-domain pointer and full-flag stage of the async FIFO: binary/Gray write pointers,
// read-pointer synchroniser, registered full and overflow flags. Optional almost_full via WR_ALMOST_FULL_EN.
module wr_ptr_full #(
   parameter int ADDRESS_WIDTH      = 4,
   parameter int DEPTH              = 16,
   parameter int ALMOST_FULL_THRESH = 12
) (
   input  logic                     wr_clk,
   input  logic                     wr_rst,
   input  logic                     wr_en,
   input  logic [ADDRESS_WIDTH:0]   rd_ptr_gray,
   output logic [ADDRESS_WIDTH-1:0] wr_addr,
   output logic [ADDRESS_WIDTH:0]   wr_ptr_gray,
   output logic                     fifo_full,
   output logic                     wr_overflow
`ifdef WR_ALMOST_FULL_EN
   ,
   output logic                     almost_full
`endif
);

   localparam int PW = ADDRESS_WIDTH + 1;

   if (DEPTH != (1 << ADDRESS_WIDTH) || ALMOST_FULL_THRESH > DEPTH) begin : g_bad_param
      $error("wr_ptr_full: DEPTH must be 2**ADDRESS_WIDTH and ALMOST_FULL_THRESH <= DEPTH");
   end

   logic [PW-1:0] wr_bin;
   logic [PW-1:0] wr_bin_next;
   logic [PW-1:0] gray_next;
   logic [PW-1:0] rq1;
   logic [PW-1:0] rq2;
   logic [PW-1:0] full_cmp;
   logic          accept;
   logic          full_next;

   assign accept      = wr_en & ~fifo_full;
   assign wr_bin_next = wr_bin + PW'(accept);
   assign gray_next   = (wr_bin_next >> 1) ^ wr_bin_next;

   // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
   assign full_cmp  = {~rq2[PW-1:PW-2], rq2[PW-3:0]};
   assign full_next = (gray_next == full_cmp);

   assign wr_addr = wr_bin[ADDRESS_WIDTH-1:0];

   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         wr_bin      <= '0;
         wr_ptr_gray <= '0;
         rq1         <= '0;
         rq2         <= '0;
         fifo_full   <= 1'b0;
         wr_overflow <= 1'b0;
      end else begin
         wr_bin      <= wr_bin_next;
         wr_ptr_gray <= gray_next;
         rq1         <= rd_ptr_gray;
         rq2         <= rq1;
         fifo_full   <= full_next;
         wr_overflow <= wr_overflow | (wr_en & fifo_full);
      end
   end

`ifdef WR_ALMOST_FULL_EN
   logic [PW-1:0] rd_bin_s;
   logic [PW-1:0] level_next;

   // Each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      rd_bin_s = '0;
      for (int i = 0; i < PW; i++) begin
         rd_bin_s[i] = ^(rq2 >> i);
      end
   end

   assign level_next = wr_bin_next - rd_bin_s;

   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         almost_full <= 1'b0;
      end else begin
         almost_full <= (level_next >= PW'(ALMOST_FULL_THRESH));
      end
   end
`endif

endmodule

// File: tb/tb_wr_ptr_full.sv
// Directed bench for wr_ptr_full: vector table for fill/overflow/drain, plus hand sequences
// for reset, wrap-around with lagging read pointer and (when enabled) almost_full.
module tb_wr_ptr_full;

   logic       wr_clk;
   logic       wr_rst;
   logic       wr_en;
   logic [4:0] rd_ptr_gray;
   logic [3:0] wr_addr;
   logic [4:0] wr_ptr_gray;
   logic       fifo_full;
   logic       wr_overflow;
   logic       almost_full;

   int checks = 0;
   int errors = 0;

   wr_ptr_full #(.ADDRESS_WIDTH(4), .DEPTH(16), .ALMOST_FULL_THRESH(12)) dut (
      .wr_clk      (wr_clk),
      .wr_rst      (wr_rst),
      .wr_en       (wr_en),
      .rd_ptr_gray (rd_ptr_gray),
      .wr_addr     (wr_addr),
      .wr_ptr_gray (wr_ptr_gray),
      .fifo_full   (fifo_full),
`ifdef WR_ALMOST_FULL_EN
      .wr_overflow (wr_overflow),
      .almost_full (almost_full)
`else
      .wr_overflow (wr_overflow)
`endif
   );

`ifndef WR_ALMOST_FULL_EN
   assign almost_full = 1'b0;
`endif

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   typedef struct {
      logic       en;
      logic [4:0] rd;
      logic [3:0] addr;
      logic [4:0] gray;
      logic       full;
      logic       ovf;
   } vec_t;

   vec_t tbl[23];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge wr_clk);
      #1;
   endtask

   function automatic logic [4:0] g(input int n);
      logic [4:0] b;
      b = 5'(n);
      return b ^ (b >> 1);
   endfunction

   initial begin
      // fill 16 with rd=0
      tbl[0]  = '{1'b1, 5'd0, 4'd1,  5'b00001, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 5'd0, 4'd2,  5'b00011, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 5'd0, 4'd3,  5'b00010, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 5'd0, 4'd4,  5'b00110, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 5'd0, 4'd5,  5'b00111, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 5'd0, 4'd6,  5'b00101, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 5'd0, 4'd7,  5'b00100, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 5'd0, 4'd8,  5'b01100, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 5'd0, 4'd9,  5'b01101, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 5'd0, 4'd10, 5'b01111, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 5'd0, 4'd11, 5'b01110, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 5'd0, 4'd12, 5'b01010, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 5'd0, 4'd13, 5'b01011, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 5'd0, 4'd14, 5'b01001, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 5'd0, 4'd15, 5'b01000, 1'b0, 1'b0};
      tbl[15] = '{1'b1, 5'd0, 4'd0,  5'b11000, 1'b1, 1'b0};
      // overflow attempts while full
      tbl[16] = '{1'b1, 5'd0, 4'd0,  5'b11000, 1'b1, 1'b1};
      tbl[17] = '{1'b1, 5'd0, 4'd0,  5'b11000, 1'b1, 1'b1};
      tbl[18] = '{1'b1, 5'd0, 4'd0,  5'b11000, 1'b1, 1'b1};
      // read pointer advances by one: full drops after the third edge
      tbl[19] = '{1'b0, 5'b00001, 4'd0, 5'b11000, 1'b1, 1'b1};
      tbl[20] = '{1'b0, 5'b00001, 4'd0, 5'b11000, 1'b1, 1'b1};
      tbl[21] = '{1'b0, 5'b00001, 4'd0, 5'b11000, 1'b0, 1'b1};
      // one more write refills it on the accepting edge
      tbl[22] = '{1'b1, 5'b00001, 4'd1, 5'b11001, 1'b1, 1'b1};

      wr_rst = 1'b0;
      wr_en = 1'b0;
      rd_ptr_gray = '0;
      #2 wr_rst = 1'b1;
      #1;
      check("reset_addr", 32'(wr_addr), 0);
      check("reset_gray", 32'(wr_ptr_gray), 0);
      check("reset_full", 32'(fifo_full), 0);
      check("reset_ovf", 32'(wr_overflow), 0);
      check("reset_af", 32'(almost_full), 0);
      step();
      step();
      wr_rst = 1'b0;

      for (int i = 0; i < 23; i++) begin
         wr_en = tbl[i].en;
         rd_ptr_gray = tbl[i].rd;
         step();
         check($sformatf("vec%0d_addr", i), 32'(wr_addr), 32'(tbl[i].addr));
         check($sformatf("vec%0d_gray", i), 32'(wr_ptr_gray), 32'(tbl[i].gray));
         check($sformatf("vec%0d_full", i), 32'(fifo_full), 32'(tbl[i].full));
         check($sformatf("vec%0d_ovf", i), 32'(wr_overflow), 32'(tbl[i].ovf));
      end

      // asynchronous reset mid-stream, observed before the next clock edge
      wr_en = 1'b0;
      #2 wr_rst = 1'b1;
      #1;
      check("midreset_addr", 32'(wr_addr), 0);
      check("midreset_gray", 32'(wr_ptr_gray), 0);
      check("midreset_full", 32'(fifo_full), 0);
      check("midreset_ovf", 32'(wr_overflow), 0);
      check("midreset_af", 32'(almost_full), 0);
      #1 wr_rst = 1'b0;
      rd_ptr_gray = '0;

      // wrap: read pointer follows the write pointer three edges behind
      begin
         int cnt;
         logic [4:0] prev;
         cnt = 0;
         prev = 5'b0;
         for (int i = 0; i < 40; i++) begin
            wr_en = 1'b1;
            rd_ptr_gray = g(cnt >= 3 ? cnt - 3 : 0);
            step();
            cnt++;
            check($sformatf("wrap%0d_addr", i), 32'(wr_addr), 32'(cnt % 16));
            check($sformatf("wrap%0d_gray", i), 32'(wr_ptr_gray), 32'(g(cnt % 32)));
            check($sformatf("wrap%0d_nofull", i), 32'(fifo_full), 0);
            check($sformatf("wrap%0d_onebit", i), 32'($countones(prev ^ wr_ptr_gray)), 1);
            prev = wr_ptr_gray;
         end
      end

`ifdef WR_ALMOST_FULL_EN
      wr_en = 1'b0;
      wr_rst = 1'b1;
      #1 wr_rst = 1'b0;
      rd_ptr_gray = '0;
      for (int k = 1; k <= 16; k++) begin
         wr_en = 1'b1;
         step();
         check($sformatf("af_w%0d", k), 32'(almost_full), (k >= 12) ? 1 : 0);
         check($sformatf("af_full_w%0d", k), 32'(fifo_full), (k == 16) ? 1 : 0);
      end
`endif

      wr_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
